// File: rtl/q8_27_pkg.sv
// Shared Q8.27 fixed-point definitions: word geometry, saturation limits,
// the divider state encoding and the sign/magnitude saturation helper.
package q8_27_pkg;

  localparam int WIDTH    = 35;
  localparam int FRAC     = 27;
  localparam int INT_BITS = WIDTH - 1 - FRAC;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             ovf;
  } sat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_ROUND,
    ST_DONE
  } div_state_t;

  // Unsigned magnitude; MAX_NEG maps to 2^34, which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] abs_q8_27(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // Applies a sign to an unsigned magnitude, clamping to the representable range.
  // A negative magnitude of exactly 2^34 is MAX_NEG and is not an overflow.
  function automatic sat_t sat_q8_27(input logic sign, input logic [WIDTH-1:0] mag);
    sat_t r;
    if (!sign && (mag > MAX_POS)) begin
      r.q   = MAX_POS;
      r.ovf = 1'b1;
    end else if (sign && (mag > MAX_NEG)) begin
      r.q   = MAX_NEG;
      r.ovf = 1'b1;
    end else begin
      r.q   = sign ? (~mag + 1'b1) : mag;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_q8_27_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and emit one quotient bit.
module div_q8_27_step
  import q8_27_pkg::*;
(
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // Keep the difference when the divisor fits, otherwise restore the remainder.
  always_comb begin
    q_bit   = (rem_in >= {1'b0, divisor});
    rem_out = q_bit ? (rem_in[WIDTH-1:0] - divisor) : rem_in[WIDTH-1:0];
  end

endmodule

// File: rtl/div_q8_27.sv
// Iterative signed Q8.27 divider, restoring radix-2 on magnitudes with
// round-half-away-from-zero and saturation. One division in flight, fixed
// latency of WIDTH+2 cycles from accept to out_valid.
// Optional build macro: DIV_Q8_27_DBZ_FLAG_EN adds the div_by_zero output.
module div_q8_27
  import q8_27_pkg::*;
(
  input  logic             clk,
  input  logic             sclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             overload
`ifdef DIV_Q8_27_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             bzero_q, bzero_d;
  logic             ovf_q, ovf_d;
  logic             exact_q, exact_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // low dividend bits still to be shifted in
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic             overload_q, overload_d;

  logic [WIDTH-1:0]          step_rem;
  logic                      step_bit;
  logic [WIDTH+INT_BITS-1:0] a_ext;
  logic [WIDTH+INT_BITS-1:0] b_ext;
  logic [WIDTH-1:0]          mag_rnd;
  sat_t                      rnd_sat;
  sat_t                      ovf_sat;
  sat_t                      exact_sat;

  div_q8_27_step u_step (
    .rem_in  ({rem_q, dvd_q[WIDTH-1]}),
    .divisor (b_mag_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // Quotient magnitude is below 128 exactly when |a| < |b| * 2^INT_BITS.
  assign a_ext = {{INT_BITS{1'b0}}, a_mag_q};
  assign b_ext = {b_mag_q, {INT_BITS{1'b0}}};

  // quo_q holds 34 magnitude bits plus a trailing half-LSB bit.
  assign mag_rnd   = {1'b0, quo_q[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, quo_q[0]};
  assign rnd_sat   = sat_q8_27(sign_q, mag_rnd);
  // With b==0 the result sign equals a's sign, so the overflow clamp also
  // yields MAX_POS for a>=0 (including 0/0) and MAX_NEG for a<0.
  assign ovf_sat   = sat_q8_27(sign_q, {WIDTH{1'b1}});
  assign exact_sat = sat_q8_27(sign_q, MAX_NEG);

  assign in_ready  = (state_q == ST_IDLE) && !sclr;
  assign out_valid = (state_q == ST_DONE);
  assign q_out     = q_out_q;
  assign overload  = overload_q;
`ifdef DIV_Q8_27_DBZ_FLAG_EN
  assign div_by_zero = (state_q == ST_DONE) && bzero_q;
`endif

  // Next-state and datapath updates for every FSM phase.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    bzero_d    = bzero_q;
    ovf_d      = ovf_q;
    exact_d    = exact_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    q_out_d    = q_out_q;
    overload_d = overload_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          a_mag_d = abs_q8_27(a);
          b_mag_d = abs_q8_27(b);
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        bzero_d = (b_mag_q == '0);
        ovf_d   = (a_ext > b_ext);
        exact_d = (a_ext == b_ext);
        // Dividend is |a| << (FRAC+1); its top bits seed the remainder.
        rem_d   = {{INT_BITS{1'b0}}, a_mag_q[WIDTH-1:INT_BITS]};
        dvd_d   = {a_mag_q[INT_BITS-1:0], {(FRAC+1){1'b0}}};
        quo_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = ST_CALC;
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (bzero_q || ovf_q) begin
          q_out_d    = ovf_sat.q;
          overload_d = ovf_sat.ovf;
        end else if (exact_q) begin
          q_out_d    = exact_sat.q;
          overload_d = exact_sat.ovf;
        end else begin
          q_out_d    = rnd_sat.q;
          overload_d = rnd_sat.ovf;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; clear aborts any division in flight.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      bzero_q    <= 1'b0;
      ovf_q      <= 1'b0;
      exact_q    <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      q_out_q    <= '0;
      overload_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      bzero_q    <= bzero_d;
      ovf_q      <= ovf_d;
      exact_q    <= exact_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      q_out_q    <= q_out_d;
      overload_q <= overload_d;
    end
  end

endmodule

// File: tb/tb_div_q8_27.sv
// Self-checking bench for div_q8_27: directed vector table, randomized
// operands against an arithmetic reference model, back-pressure and
// mid-operation clear sequences.
module tb_div_q8_27;

  localparam logic [34:0] MAXP = 35'h3FFFFFFFF;
  localparam logic [34:0] MAXN = 35'h400000000;

  logic        clk = 1'b0;
  logic        sclr = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [34:0] a = '0;
  logic [34:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [34:0] q_out;
  logic        overload;
`ifdef DIV_Q8_27_DBZ_FLAG_EN
  logic        div_by_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_q8_27 dut (
    .clk       (clk),
    .sclr      (sclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .overload  (overload)
`ifdef DIV_Q8_27_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  typedef struct {
    logic [34:0] a;
    logic [34:0] b;
    logic [34:0] q;
    logic        ovl;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic dbz_now();
`ifdef DIV_Q8_27_DBZ_FLAG_EN
    return div_by_zero;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: exact rational quotient, rounded half away from zero, then clamped.
  function automatic void model(input logic [34:0] av, input logic [34:0] bv,
                                output logic [34:0] q, output logic ovl);
    longint sa = longint'($signed(av));
    longint sb = longint'($signed(bv));
    longint unsigned ma = (sa < 0) ? longint'(-sa) : sa;
    longint unsigned mb = (sb < 0) ? longint'(-sb) : sb;
    bit neg = (sa < 0) != (sb < 0);
    longint unsigned mag;
    if (mb == 0) begin
      q = (sa < 0) ? MAXN : MAXP;
      ovl = 1'b1;
    end else if (ma > 128 * mb) begin
      q = neg ? MAXN : MAXP;
      ovl = 1'b1;
    end else begin
      mag = (ma * (64'd1 << 28) + mb) / (2 * mb);
      if (!neg && mag >= (64'd1 << 34)) begin
        q = MAXP;
        ovl = 1'b1;
      end else begin
        q = neg ? 35'(-mag) : 35'(mag);
        ovl = 1'b0;
      end
    end
  endfunction

  function automatic logic [34:0] rnd_q(input int maxshift);
    logic [63:0] r = {$urandom, $urandom};
    logic signed [34:0] v = r[34:0];
    v = v >>> $urandom_range(0, maxshift);
    return v;
  endfunction

  // Issue one division with out_ready high; called #1 after a clock edge.
  task automatic run_op(input logic [34:0] ai, input logic [34:0] bi,
                        output logic [34:0] q, output logic ovl, output logic dbz,
                        output int lat, output bit tmo);
    int g = 0;
    tmo = 1'b0;
    lat = 0;
    a = ai;
    b = bi;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) tmo = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, 3'b0};
    b = {$urandom, 3'b0};
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    q = q_out;
    ovl = overload;
    dbz = dbz_now();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[15];
    logic [34:0] q, eq, ra, rb;
    logic ovl, eovl, dbz;
    int lat;
    bit tmo;
    bit bad;
    int g;

    tbl[0]  = '{35'h018000000, 35'h010000000, 35'h00C000000, 1'b0, 1'b0}; //  3.0 / 2.0
    tbl[1]  = '{35'h7F8000000, 35'h018000000, 35'h7FD555555, 1'b0, 1'b0}; // -1.0 / 3.0
    tbl[2]  = '{35'h320000000, 35'h004000000, MAXP,          1'b1, 1'b0}; //  100 / 0.5
    tbl[3]  = '{35'h4E0000000, 35'h004000000, MAXN,          1'b1, 1'b0}; // -100 / 0.5
    tbl[4]  = '{35'h028000000, 35'h000000000, MAXP,          1'b1, 1'b1}; //  5.0 / 0
    tbl[5]  = '{35'h7D8000000, 35'h000000000, MAXN,          1'b1, 1'b1}; // -5.0 / 0
    tbl[6]  = '{35'h000000000, 35'h000000000, MAXP,          1'b1, 1'b1}; //  0 / 0
    tbl[7]  = '{MAXN,          35'h008000000, MAXN,          1'b0, 1'b0}; // MAX_NEG / 1.0
    tbl[8]  = '{MAXN,          35'h7F8000000, MAXP,          1'b1, 1'b0}; // MAX_NEG / -1.0
    tbl[9]  = '{35'h200000000, 35'h004000000, MAXP,          1'b1, 1'b0}; //  64 / 0.5 exact
    tbl[10] = '{35'h600000000, 35'h004000000, MAXN,          1'b0, 1'b0}; // -64 / 0.5 exact
    tbl[11] = '{35'h000000001, 35'h010000000, 35'h000000001, 1'b0, 1'b0}; //  half LSB up
    tbl[12] = '{35'h7FFFFFFFF, 35'h010000000, 35'h7FFFFFFFF, 1'b0, 1'b0}; // -half LSB away
    tbl[13] = '{35'h000000000, 35'h7F8000000, 35'h000000000, 1'b0, 1'b0}; //  0 / -1.0
    tbl[14] = '{35'h7F8000000, 35'h7F8000000, 35'h008000000, 1'b0, 1'b0}; // -1.0 / -1.0

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_overload", overload, 0);
    chk("rst_dbz", dbz_now(), 0);
    sclr = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].a, tbl[i].b, q, ovl, dbz, lat, tmo);
      $display("vec %0d: a=%h b=%h -> q=%h ovl=%0d lat=%0d", i, tbl[i].a, tbl[i].b, q, ovl, lat);
      chk($sformatf("tbl%0d_timeout", i), tmo, 0);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_ovl", i), ovl, tbl[i].ovl);
      chk($sformatf("tbl%0d_lat", i), lat, 37);
`ifdef DIV_Q8_27_DBZ_FLAG_EN
      chk($sformatf("tbl%0d_dbz", i), dbz, tbl[i].dbz);
`endif
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = rnd_q($urandom_range(0, 12));
      rb = ($urandom_range(0, 7) == 0) ? 35'h0 : rnd_q($urandom_range(0, 12));
      model(ra, rb, eq, eovl);
      run_op(ra, rb, q, ovl, dbz, lat, tmo);
      $display("rnd %0d: a=%h b=%h -> q=%h ovl=%0d (model %h %0d)", i, ra, rb, q, ovl, eq, eovl);
      chk($sformatf("rnd%0d_timeout", i), tmo, 0);
      chk($sformatf("rnd%0d_q", i), q, eq);
      chk($sformatf("rnd%0d_ovl", i), ovl, eovl);
`ifdef DIV_Q8_27_DBZ_FLAG_EN
      chk($sformatf("rnd%0d_dbz", i), dbz, (rb == 0));
`endif
    end

    // Back-pressure: result held for 10 cycles with out_ready low
    out_ready = 1'b0;
    a = 35'h018000000;
    b = 35'h010000000;
    in_valid = 1'b1;
    @(posedge clk); #1;            // accept (in_ready was high)
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_latency", g, 37);
    bad = 1'b0;
    in_valid = 1'b1;               // must be ignored while busy
    a = 35'h028000000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || q_out !== 35'h00C000000 || overload !== 1'b0 || in_ready !== 1'b0)
        bad = 1'b1;
    end
    in_valid = 1'b0;
    $display("backpressure: q=%h held, stable=%0d", q_out, !bad);
    chk("bp_hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Clear at CALC cycle 12 aborts silently
    a = 35'h7D8000000;
    b = 35'h010000000;
    in_valid = 1'b1;
    @(posedge clk); #1;            // accept
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    sclr = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready_during_sclr", in_ready, 0);
    sclr = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    $display("abort: spurious out_valid=%0d", bad);
    chk("abort_no_output", bad, 0);
    chk("abort_idle", in_ready, 1);
    model(35'h7D8000000, 35'h010000000, eq, eovl);
    run_op(35'h7D8000000, 35'h010000000, q, ovl, dbz, lat, tmo);
    $display("post-abort: q=%h ovl=%0d lat=%0d", q, ovl, lat);
    chk("post_abort_timeout", tmo, 0);
    chk("post_abort_q", q, eq);
    chk("post_abort_ovl", ovl, eovl);
    chk("post_abort_lat", lat, 37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
